// File: rtl/if_id_buffer_pkg.sv
// Shared widths and constants for the fetch/decode decoupling buffer.
package if_id_buffer_pkg;

    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic RST_ACTIVE = 1'b1;
    localparam logic FLUSH_ENABLE = 1'b1;

    function automatic logic pc_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_id_buffer_sync_fifo.sv
// Generic DEPTH x W register FIFO with synchronous clear.
module sync_fifo
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    // Storage carries no reset; the consumer masks the empty head.
    always_ff @(posedge clk) begin
        if (push && !clear && rst != RST_ACTIVE) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: FIFO of {pc, inst, misalign} with
// valid/ready handshakes and flush on redirect.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = XLEN_DEF,
    parameter int ILEN  = ILEN_DEF,
    parameter logic [ILEN-1:0] NOP_INST = ILEN'(NOP_INST_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [ILEN-1:0] in_inst_i,
    output logic            in_ready_o,
    output logic            hold_req_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [ILEN-1:0] out_inst_o,
    output logic            out_misalign_o
);

    localparam int W = XLEN + ILEN + 1;

    logic         flush;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;

    assign flush = (flush_i == FLUSH_ENABLE);
    assign push  = in_valid_i && in_ready_o && !flush;
    assign pop   = out_valid_o && out_ready_i && !flush;
    assign wdata = {in_pc_i, in_inst_i, pc_misaligned(in_pc_i[1:0])};

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    // Ready depends only on registered occupancy: no ready-to-ready path.
    assign in_ready_o  = !full;
    assign hold_req_o  = full;
    assign out_valid_o = !empty;

    always_comb begin
        out_pc_o       = '0;
        out_inst_o     = NOP_INST;
        out_misalign_o = 1'b0;
        if (!empty) begin
            out_pc_o       = rdata[W-1 -: XLEN];
            out_inst_o     = rdata[ILEN:1];
            out_misalign_o = rdata[0];
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: directed pushes with hand-set
// acceptance, monitor pops and compares on each decode handshake.
module tb_if_id_buffer;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic [63:0] in_pc_i;
    logic [31:0] in_inst_i;
    logic        in_ready_o;
    logic        hold_req_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_pc_o;
    logic [31:0] out_inst_o;
    logic        out_misalign_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    if_id_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_pc_i        (in_pc_i),
        .in_inst_i      (in_inst_i),
        .in_ready_o     (in_ready_o),
        .hold_req_o     (hold_req_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_pc_o       (out_pc_o),
        .out_inst_o     (out_inst_o),
        .out_misalign_o (out_misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [63:0] pc);
        return {20'hABCDE, pc[11:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; acc is the hand-computed acceptance.
    task automatic cyc(input logic v, input logic [63:0] pc,
                       input logic rdy, input logic fl, input logic acc);
        in_valid_i  = v;
        in_pc_i     = pc;
        in_inst_i   = mk_inst(pc);
        out_ready_i = rdy;
        flush_i     = fl;
        if (fl) sb.delete();
        if (acc) sb.push_back('{pc, mk_inst(pc), pc[1:0] != 2'b00});
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake away from the edge means a pop at the next edge.
    always @(negedge clk) begin
        if (!rst && !flush_i && out_valid_o && out_ready_i) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected none",
                         out_pc_o);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", out_pc_o, e.pc);
                chk("pop_inst", 64'(out_inst_o), 64'(e.inst));
                chk("pop_mis", 64'(out_misalign_o), 64'(e.mis));
            end
        end
    end

    task automatic chk_empty(input string name);
        chk({name, "_valid"}, 64'(out_valid_o), 64'd0);
        chk({name, "_pc"}, out_pc_o, 64'd0);
        chk({name, "_inst"}, 64'(out_inst_o), 64'h13);
        chk({name, "_ready"}, 64'(in_ready_o), 64'd1);
        chk({name, "_hold"}, 64'(hold_req_o), 64'd0);
    endtask

    localparam logic [63:0] B = 64'h8000_0000;

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        in_pc_i = '0;
        in_inst_i = '0;
        out_ready_i = 1'b0;

        cyc(1, B, 1, 0, 0);
        chk_empty("rst1");
        cyc(1, B + 4, 1, 0, 0);
        chk_empty("rst2");
        rst = 1'b0;
        cyc(0, 0, 1, 0, 0);
        chk_empty("post_rst");

        // streaming
        cyc(1, B, 1, 0, 1);
        chk("s0_valid", 64'(out_valid_o), 64'd1);
        chk("s0_pc", out_pc_o, B);
        chk("s0_ready", 64'(in_ready_o), 64'd1);
        cyc(1, B + 4, 1, 0, 1);
        chk("s1_pc", out_pc_o, B + 4);
        chk("s1_ready", 64'(in_ready_o), 64'd1);
        cyc(1, B + 8, 1, 0, 1);
        chk("s2_pc", out_pc_o, B + 8);
        chk("s2_inst", 64'(out_inst_o), 64'(mk_inst(B + 8)));
        cyc(0, 0, 1, 0, 0);
        chk_empty("s_drain");

        // back-pressure
        cyc(1, B, 0, 0, 1);
        chk("bp1_ready", 64'(in_ready_o), 64'd1);
        cyc(1, B + 4, 0, 0, 1);
        chk("bp_full_ready", 64'(in_ready_o), 64'd0);
        chk("bp_full_hold", 64'(hold_req_o), 64'd1);
        chk("bp_head", out_pc_o, B);
        cyc(1, B + 8, 0, 0, 0);
        chk("bp_hold_pc", out_pc_o, B);
        chk("bp_hold_ready", 64'(in_ready_o), 64'd0);
        cyc(1, B + 12, 1, 0, 0);
        chk("bp_pop_ready", 64'(in_ready_o), 64'd1);
        chk("bp_pop_head", out_pc_o, B + 4);

        // flush with full buffer and simultaneous push
        cyc(1, B + 16, 0, 0, 1);
        chk("fl_full", 64'(in_ready_o), 64'd0);
        cyc(1, B + 'h100, 1, 1, 0);
        chk_empty("fl_after");
        cyc(1, B + 'h180, 1, 1, 0);
        chk_empty("fl_twice");
        cyc(1, B + 'h200, 0, 0, 1);
        chk("fl_new_head", out_pc_o, B + 'h200);
        cyc(0, 0, 1, 0, 0);
        chk("fl_drain", 64'(out_valid_o), 64'd0);

        // misaligned
        cyc(1, B + 2, 0, 0, 1);
        chk("mis_pc", out_pc_o, B + 2);
        chk("mis_flag", 64'(out_misalign_o), 64'd1);
        cyc(1, B + 4, 1, 0, 1);
        chk("mis_next_pc", out_pc_o, B + 4);
        chk("mis_clear", 64'(out_misalign_o), 64'd0);
        cyc(0, 0, 1, 0, 0);

        // wrap-around: fill/drain rounds
        for (int r = 0; r < 3; r++) begin
            logic [63:0] p;
            p = B + 64'h1000 + 64'(r * 8);
            cyc(1, p, 0, 0, 1);
            cyc(1, p + 4, 0, 0, 1);
            chk("wr_full", 64'(in_ready_o), 64'd0);
            chk("wr_head", out_pc_o, p);
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 1, 0, 0);
            chk("wr_empty", 64'(out_valid_o), 64'd0);
        end

        cyc(0, 0, 0, 0, 0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
